frame_packetizer: RTL and testbench
===================================

# frame_packetizer

Downstream stage of the ADC sextet packer. Reads the packer's 64-bit sextet words from the clock-crossing FIFO in the `clk` domain. Checks the per-frame sextet index sequence and wraps each complete frame between a header word and a trailer word. Drives a valid/ready stream towards the host transfer engine.

## Interface
Parameters:
- `IDX_W`, default 13: sextet index width; must match input bits [60:48].
- `FCNT_W`, default 32: frame counter width, carried in header and trailer [31:0].

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_length`  in  13  last valid sextet index (frame holds frame_length+1 sextets); sampled only at header emission.
- `in_data`  in  64  FIFO word, show-ahead:
  - [63] ADC select
  - [62] half-clock shift
  - [61] switcher
  - [60:48] sextet index
  - [47:0] six samples
- `in_valid`  in  1  FIFO not empty.
- `in_ready`  out  1  FIFO read strobe; a word is consumed when in_valid & in_ready.
- `out_data`  out  64  output word.
- `out_valid`  out  1  out_data valid.
- `out_ready`  in  1  sink accepts; transfer when out_valid & out_ready.
- `out_sof`  out  1  marks header word.
- `out_eof`  out  1  marks trailer word.
- `frame_cnt`  out  32  frames started since reset.
- `err_cnt`  out  16  frames closed with error, saturating at 16'hFFFF.

## Operation
- FSM states and transitions:
  - HUNT: consume and discard every valid word whose index is not 0. When a valid word has index 0, do not consume it; go to HEADER.
  - HEADER: when the output slot is free, emit the header word:
    - [63:48] = 16'hA55A
    - [47:45] = {ADC, shift, switcher} of the pending word
    - [44:32] = frame_length
    - [31:0] = frame_cnt
    - Assert out_sof. Latch frame_length into `len_q` and the three flag bits into `flags_q`. Set `exp_idx` = 0; increment frame_cnt. Go to BODY.
  - BODY: each consumed word is checked against two conditions:
    - index == exp_idx
    - bits [63:61] == flags_q
    - If both match: forward the word unchanged. If index == len_q, go to TRAILER with err = 0; otherwise exp_idx++.
    - On any mismatch: do not forward or consume the offending word; go to TRAILER with err = 1.
  - TRAILER: emit the trailer word:
    - [63:48] = 16'h5AA5
    - [47] = err
    - [46:45] = 0
    - [44:32] = last forwarded index (0 if none was forwarded)
    - [31:0] = frame number of this frame
    - Assert out_eof. If err, increment err_cnt (saturating). Go to HUNT.
- The word that triggered a mismatch is re-examined in HUNT. An index-0 word there starts a new frame immediately.
- frame_cnt wraps modulo 2^32.
- frame_length changes during BODY have no effect until the next HEADER.

## Timing
- Output is a single register stage. out_data, out_valid, out_sof and out_eof change only on clk edges.
- in_ready is combinational:
  - In BODY: (out_valid==0 | out_ready).
  - In HUNT: 1 when the FIFO head index != 0, else 0.
  - In HEADER and TRAILER: 0.
- Latency: an input word consumed at edge N appears on out_data after edge N. Sustained throughput is 1 word/clk with out_ready high.
- Frame overhead is exactly 2 output cycles (header and trailer).
- out_ready low holds out_data and its flags stable, and stalls the FIFO. No word is ever dropped or duplicated under backpressure.
- If out_valid is asserted, it stays high until accepted.
- Reset: all of the following clear asynchronously on rst_n low: out_valid, out_sof, out_eof, out_data, frame_cnt, err_cnt, exp_idx; state returns to HUNT.
  - A frame interrupted by reset gets no trailer.
  - After release, the first output is a header whose frame number is 0.
- in_valid low in BODY just waits; there is no timeout.

## Structure
- Shared package `dragon_pkg`:
  - SOF_MARK = 16'hA55A, EOF_MARK = 16'h5AA5
  - input field bit positions
  - state enum {HUNT, HEADER, BODY, TRAILER}
- One natural sub-module: `out_stage_reg`, a 64+2-bit valid/ready holding register. It is reusable by other stream stages.

## Test plan
- frame_length = 3, indices 0..3 streamed, out_ready = 1 → output is A55A header (frame 0), 4 data words identical to input, then 5AA5 trailer with err = 0 and last index = 3; frame_cnt = 1.
- Leading junk indices 7, 8, then 0..3 → 7 and 8 discarded; one clean frame is output, same as the previous scenario.
- Indices 0, 1, 3 with frame_length = 3 → header, words 0 and 1, trailer err = 1 with last index = 1; word 3 is dropped in HUNT; err_cnt = 1.
- Switcher bit toggles at index 2 with frame_length = 5 → trailer err = 1 with last index = 1.
- out_ready toggled randomly for 1000 frames with frame_length = 0 → every frame emits exactly 3 words; out_data is stable while stalled; no loss.
- rst_n pulsed low mid-BODY → outputs cleared asynchronously; the next frame header carries frame number 0.

Source files
------------

// File: rtl/dragon_pkg.sv
// Shared definitions for the ADC sextet stream stages: frame markers,
// input word field positions and the packetizer state encoding.
package dragon_pkg;

    localparam logic [15:0] SOF_MARK = 16'hA55A;
    localparam logic [15:0] EOF_MARK = 16'h5AA5;

    // Input sextet word layout
    localparam int ADC_BIT    = 63;
    localparam int SHIFT_BIT  = 62;
    localparam int SWITCH_BIT = 61;
    localparam int FLAGS_MSB  = ADC_BIT;
    localparam int FLAGS_LSB  = SWITCH_BIT;
    localparam int IDX_MSB    = 60;
    localparam int IDX_LSB    = 48;
    localparam int SAMPLE_MSB = 47;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HEADER  = 2'd1,
        BODY    = 2'd2,
        TRAILER = 2'd3
    } state_t;

endpackage

// File: rtl/out_stage_reg.sv
// Single-entry valid/ready holding register. Loads whenever it is empty or
// its content is being accepted, so it sustains one word per clock and keeps
// data stable while the sink stalls.
module out_stage_reg #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] inData,
    input  logic         inValid,
    output logic         inReady,
    output logic [W-1:0] outData,
    output logic         outValid,
    input  logic         outReady
);

    assign inReady = !outValid || outReady;

    // Holding register; data only reloads when a new word is taken in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outData  <= '0;
        end else if (inReady) begin
            outValid <= inValid;
            if (inValid) begin
                outData <= inData;
            end
        end
    end

endmodule

// File: rtl/frame_packetizer.sv
// Frame packetizer: hunts for sextet index 0, checks the index sequence and
// flag bits of each frame, and wraps the frame between a header and a
// trailer word on a registered valid/ready output.
//
// state   | meaning
// HUNT    | discard words until the FIFO head carries index 0
// HEADER  | emit header for the pending index-0 word, latch frame setup
// BODY    | forward words while index and flags match expectation
// TRAILER | emit trailer with error flag and last forwarded index
module frame_packetizer
    import dragon_pkg::*;
#(
    parameter int IDX_W  = 13,
    parameter int FCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  frame_length,
    input  logic [63:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [63:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [15:0]       err_cnt
);

    state_t state, stateNext;

    logic [IDX_W-1:0]  len_q;
    logic [2:0]        flags_q;
    logic [IDX_W-1:0]  exp_idx;
    logic [IDX_W-1:0]  lastIdx;
    logic [FCNT_W-1:0] curFrame;
    logic              errQ;

    logic [IDX_W-1:0] headIdx;
    logic [2:0]       headFlags;
    logic             match;
    logic             isLast;
    logic             slotFree;
    logic             push;
    logic [65:0]      pushData;
    logic [65:0]      stageData;

    assign headIdx   = in_data[IDX_LSB +: IDX_W];
    assign headFlags = in_data[FLAGS_MSB:FLAGS_LSB];
    assign match     = (headIdx == exp_idx) && (headFlags == flags_q);
    assign isLast    = (headIdx == len_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode.
    always_comb begin
        stateNext = state;
        case (state)
            HUNT: begin
                if (in_valid && headIdx == '0) begin
                    stateNext = HEADER;
                end
            end
            HEADER: begin
                if (in_valid && slotFree) begin
                    stateNext = BODY;
                end
            end
            BODY: begin
                if (in_valid) begin
                    if (!match) begin
                        stateNext = TRAILER;
                    end else if (slotFree && isLast) begin
                        stateNext = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (slotFree) begin
                    stateNext = HUNT;
                end
            end
            default: stateNext = HUNT;
        endcase
    end

    // Output decode: FIFO read strobe and the word offered to the output stage.
    // A mismatching word is never read in BODY so HUNT can re-examine it.
    always_comb begin
        in_ready = 1'b0;
        push     = 1'b0;
        pushData = '0;
        case (state)
            HUNT: begin
                in_ready = (headIdx != '0);
            end
            HEADER: begin
                push     = in_valid;
                pushData = {1'b1, 1'b0, SOF_MARK, headFlags, frame_length, frame_cnt};
            end
            BODY: begin
                in_ready = slotFree && (!in_valid || match);
                push     = in_valid && match;
                pushData = {1'b0, 1'b0, in_data};
            end
            TRAILER: begin
                push     = 1'b1;
                pushData = {1'b0, 1'b1, EOF_MARK, errQ, 2'b00, lastIdx, curFrame};
            end
            default: ;
        endcase
    end

    // Frame bookkeeping: setup latched at header, progress tracked in body.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            flags_q   <= '0;
            exp_idx   <= '0;
            lastIdx   <= '0;
            curFrame  <= '0;
            errQ      <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                HEADER: begin
                    if (in_valid && slotFree) begin
                        len_q     <= frame_length;
                        flags_q   <= headFlags;
                        exp_idx   <= '0;
                        lastIdx   <= '0;
                        errQ      <= 1'b0;
                        curFrame  <= frame_cnt;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                BODY: begin
                    if (in_valid) begin
                        if (!match) begin
                            errQ <= 1'b1;
                        end else if (slotFree) begin
                            lastIdx <= headIdx;
                            exp_idx <= exp_idx + 1'b1;
                        end
                    end
                end
                TRAILER: begin
                    if (slotFree && errQ && err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    out_stage_reg #(.W(66)) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .inData   (pushData),
        .inValid  (push),
        .inReady  (slotFree),
        .outData  (stageData),
        .outValid (out_valid),
        .outReady (out_ready)
    );

    assign {out_sof, out_eof, out_data} = stageData;

endmodule

// File: tb/tb_frame_packetizer.sv
// Directed bench for frame_packetizer with a show-ahead FIFO model on the
// input and a capture queue on the output.
module tb_frame_packetizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] frame_length = '0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof;
    logic        out_eof;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int failures = 0;

    logic [63:0] inQ[$];
    logic [65:0] outQ[$];
    bit          bpMode = 1'b0;
    int          stallViol = 0;
    logic [65:0] prevWord = '0;
    bit          prevStall = 1'b0;

    frame_packetizer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_length (frame_length),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wd(input logic [2:0] f, input logic [12:0] idx, input logic [47:0] s);
        return {f, idx, s};
    endfunction

    function automatic logic [65:0] hdr(input logic [2:0] f, input logic [12:0] len, input logic [31:0] fn);
        return {2'b10, 16'hA55A, f, len, fn};
    endfunction

    function automatic logic [65:0] trl(input logic err, input logic [12:0] last, input logic [31:0] fn);
        return {2'b01, 16'h5AA5, err, 2'b00, last, fn};
    endfunction

    // FIFO model: handshake decided mid-cycle, popped just after the edge.
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = in_valid && in_ready && rst_n;
            @(posedge clk);
            #1;
            if (fire && inQ.size() > 0) void'(inQ.pop_front());
            if (bpMode) out_ready = 1'($urandom_range(0, 1));
            if (inQ.size() > 0) begin
                in_valid = 1'b1;
                in_data  = inQ[0];
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
    end

    // Output capture and stall-stability tracking.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) outQ.push_back({out_sof, out_eof, out_data});
            if (prevStall && (!out_valid || {out_sof, out_eof, out_data} !== prevWord)) stallViol++;
            prevStall = out_valid && !out_ready;
            prevWord  = {out_sof, out_eof, out_data};
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic wait_out(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (outQ.size() >= n) break;
            @(negedge clk);
        end
        ok = (outQ.size() >= n);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0)
            $display("FAIL reset_flags: got valid=%b sof=%b eof=%b, want 0 0 0", out_valid, out_sof, out_eof);
        checks++;
        if (out_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: got %h, want 0", out_data);
        end
        checks++;
        if (frame_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got frame_cnt=%0d err_cnt=%0d, want 0 0", frame_cnt, err_cnt);
        end
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0) failures++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
        end
    endtask

    task automatic test_clean;
        logic [65:0] exp[$];
        logic [65:0] act;
        bit ok;
        outQ.delete();
        frame_length = 13'd3;
        exp.push_back(hdr(3'b101, 13'd3, 32'd0));
        for (int i = 0; i < 4; i++) begin
            inQ.push_back(wd(3'b101, 13'(i), 48'h1111_2222_0000 + 48'(i)));
            exp.push_back({2'b00, wd(3'b101, 13'(i), 48'h1111_2222_0000 + 48'(i))});
        end
        exp.push_back(trl(1'b0, 13'd3, 32'd0));
        wait_out(6, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL clean_timeout: got %0d words, want 6", outQ.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < outQ.size()) ? outQ[i] : 'x;
            checks++;
            if (act !== exp[i]) begin
                failures++;
                $display("FAIL clean_word%0d: got %h, want %h", i, act, exp[i]);
            end
        end
        checks++;
        if (frame_cnt !== 32'd1) begin
            failures++;
            $display("FAIL clean_frame_cnt: got %0d, want 1", frame_cnt);
        end
    endtask

    task automatic test_junk;
        logic [65:0] exp[$];
        logic [65:0] act;
        bit ok;
        outQ.delete();
        frame_length = 13'd3;
        inQ.push_back(wd(3'b000, 13'd7, 48'hDEAD));
        inQ.push_back(wd(3'b000, 13'd8, 48'hBEEF));
        exp.push_back(hdr(3'b011, 13'd3, 32'd1));
        for (int i = 0; i < 4; i++) begin
            inQ.push_back(wd(3'b011, 13'(i), 48'hABC0 + 48'(i)));
            exp.push_back({2'b00, wd(3'b011, 13'(i), 48'hABC0 + 48'(i))});
        end
        exp.push_back(trl(1'b0, 13'd3, 32'd1));
        wait_out(6, 200, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (outQ.size() != 6) begin
            failures++;
            $display("FAIL junk_count: got %0d words, want 6", outQ.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < outQ.size()) ? outQ[i] : 'x;
            checks++;
            if (act !== exp[i]) begin
                failures++;
                $display("FAIL junk_word%0d: got %h, want %h", i, act, exp[i]);
            end
        end
    endtask

    task automatic test_gap;
        logic [65:0] exp[$];
        logic [65:0] act;
        bit ok;
        outQ.delete();
        frame_length = 13'd3;
        inQ.push_back(wd(3'b010, 13'd0, 48'h10));
        inQ.push_back(wd(3'b010, 13'd1, 48'h11));
        inQ.push_back(wd(3'b010, 13'd3, 48'h13));
        exp.push_back(hdr(3'b010, 13'd3, 32'd2));
        exp.push_back({2'b00, wd(3'b010, 13'd0, 48'h10)});
        exp.push_back({2'b00, wd(3'b010, 13'd1, 48'h11)});
        exp.push_back(trl(1'b1, 13'd1, 32'd2));
        wait_out(4, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (outQ.size() != 4 || inQ.size() != 0) begin
            failures++;
            $display("FAIL gap_count: got out=%0d left=%0d, want 4 0", outQ.size(), inQ.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < outQ.size()) ? outQ[i] : 'x;
            checks++;
            if (act !== exp[i]) begin
                failures++;
                $display("FAIL gap_word%0d: got %h, want %h", i, act, exp[i]);
            end
        end
        checks++;
        if (err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL gap_err_cnt: got %0d, want 1", err_cnt);
        end
    endtask

    task automatic test_flag;
        logic [65:0] exp[$];
        logic [65:0] act;
        bit ok;
        outQ.delete();
        frame_length = 13'd5;
        inQ.push_back(wd(3'b000, 13'd0, 48'h20));
        inQ.push_back(wd(3'b000, 13'd1, 48'h21));
        inQ.push_back(wd(3'b001, 13'd2, 48'h22));
        exp.push_back(hdr(3'b000, 13'd5, 32'd3));
        exp.push_back({2'b00, wd(3'b000, 13'd0, 48'h20)});
        exp.push_back({2'b00, wd(3'b000, 13'd1, 48'h21)});
        exp.push_back(trl(1'b1, 13'd1, 32'd3));
        wait_out(4, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (outQ.size() != 4 || inQ.size() != 0) begin
            failures++;
            $display("FAIL flag_count: got out=%0d left=%0d, want 4 0", outQ.size(), inQ.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < outQ.size()) ? outQ[i] : 'x;
            checks++;
            if (act !== exp[i]) begin
                failures++;
                $display("FAIL flag_word%0d: got %h, want %h", i, act, exp[i]);
            end
        end
        checks++;
        if (err_cnt !== 16'd2) begin
            failures++;
            $display("FAIL flag_err_cnt: got %0d, want 2", err_cnt);
        end
    endtask

    task automatic test_len_hold;
        logic [65:0] exp[$];
        logic [65:0] act;
        bit ok;
        outQ.delete();
        frame_length = 13'd2;
        inQ.push_back(wd(3'b111, 13'd0, 48'h30));
        wait_out(2, 200, ok);
        frame_length = 13'd5;
        inQ.push_back(wd(3'b111, 13'd1, 48'h31));
        inQ.push_back(wd(3'b111, 13'd2, 48'h32));
        inQ.push_back(wd(3'b111, 13'd3, 48'h33));
        exp.push_back(hdr(3'b111, 13'd2, 32'd4));
        exp.push_back({2'b00, wd(3'b111, 13'd0, 48'h30)});
        exp.push_back({2'b00, wd(3'b111, 13'd1, 48'h31)});
        exp.push_back({2'b00, wd(3'b111, 13'd2, 48'h32)});
        exp.push_back(trl(1'b0, 13'd2, 32'd4));
        wait_out(5, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (outQ.size() != 5) begin
            failures++;
            $display("FAIL lenhold_count: got %0d words, want 5", outQ.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < outQ.size()) ? outQ[i] : 'x;
            checks++;
            if (act !== exp[i]) begin
                failures++;
                $display("FAIL lenhold_word%0d: got %h, want %h", i, act, exp[i]);
            end
        end
        checks++;
        if (frame_cnt !== 32'd5) begin
            failures++;
            $display("FAIL lenhold_frame_cnt: got %0d, want 5", frame_cnt);
        end
    endtask

    task automatic test_backpressure;
        logic [65:0] act;
        logic [65:0] e;
        logic [63:0] w;
        bit ok;
        int nFail = 0;
        outQ.delete();
        frame_length = 13'd0;
        stallViol = 0;
        for (int f = 0; f < 1000; f++) inQ.push_back(wd(3'(f), 13'd0, 48'(f)));
        bpMode = 1'b1;
        wait_out(3000, 40000, ok);
        bpMode = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (outQ.size() != 3000 || inQ.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got out=%0d left=%0d, want 3000 0", outQ.size(), inQ.size());
        end
        for (int f = 0; f < 1000; f++) begin
            w = wd(3'(f), 13'd0, 48'(f));
            for (int k = 0; k < 3; k++) begin
                e = (k == 0) ? hdr(3'(f), 13'd0, 32'(5 + f)) :
                    (k == 1) ? {2'b00, w} : trl(1'b0, 13'd0, 32'(5 + f));
                act = (3 * f + k < outQ.size()) ? outQ[3 * f + k] : 'x;
                checks++;
                if (act !== e) begin
                    failures++;
                    nFail++;
                    if (nFail <= 10) $display("FAIL bp_frame%0d_word%0d: got %h, want %h", f, k, act, e);
                end
            end
        end
        checks++;
        if (stallViol != 0) begin
            failures++;
            $display("FAIL bp_stall_stable: got %0d changes while stalled, want 0", stallViol);
        end
        checks++;
        if (frame_cnt !== 32'd1005 || err_cnt !== 16'd2) begin
            failures++;
            $display("FAIL bp_counters: got frame_cnt=%0d err_cnt=%0d, want 1005 2", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [65:0] exp[$];
        logic [65:0] act;
        bit ok;
        outQ.delete();
        frame_length = 13'd3;
        inQ.push_back(wd(3'b000, 13'd0, 48'h40));
        inQ.push_back(wd(3'b000, 13'd1, 48'h41));
        wait_out(3, 200, ok);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0 || out_data !== 64'h0) begin
            failures++;
            $display("FAIL midreset_outputs: got valid=%b sof=%b eof=%b data=%h, want all 0",
                     out_valid, out_sof, out_eof, out_data);
        end
        checks++;
        if (frame_cnt !== 32'd0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midreset_counters: got frame_cnt=%0d err_cnt=%0d, want 0 0", frame_cnt, err_cnt);
        end
        inQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        outQ.delete();
        exp.push_back(hdr(3'b100, 13'd3, 32'd0));
        for (int i = 0; i < 4; i++) begin
            inQ.push_back(wd(3'b100, 13'(i), 48'h50 + 48'(i)));
            exp.push_back({2'b00, wd(3'b100, 13'(i), 48'h50 + 48'(i))});
        end
        exp.push_back(trl(1'b0, 13'd3, 32'd0));
        wait_out(6, 200, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (outQ.size() != 6) begin
            failures++;
            $display("FAIL midreset_count: got %0d words, want 6", outQ.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            act = (i < outQ.size()) ? outQ[i] : 'x;
            checks++;
            if (act !== exp[i]) begin
                failures++;
                $display("FAIL midreset_word%0d: got %h, want %h", i, act, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_junk();
        test_gap();
        test_flag();
        test_len_hold();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
